// File: rtl/clock_tree_controller.sv
// Derives NR_OF_CHANNELS slow clock levels from one free-running base tick,
// with halt / run / single-step control and a channel-0 rising-edge counter.
module clock_tree_controller #(
    parameter int          NR_OF_CHANNELS = 2,
    parameter int          TICK_BITS      = 32,
    parameter int          RELOAD_VALUE   = 200000,
    parameter int          HIGH_TICKS     = 1,
    parameter int          LOW_TICKS      = 1,
    parameter logic [63:0] CH_DIV         = '0
) (
    input  logic                      GlobalClock,
    input  logic                      RST,
    input  logic [1:0]                Mode,
    input  logic                      Go,
    output logic [NR_OF_CHANNELS-1:0] ClkLevel,
    output logic [NR_OF_CHANNELS-1:0] ClkRise,
    output logic [NR_OF_CHANNELS-1:0] ClkFall,
    output logic                      Running,
    output logic [31:0]               CycleCount,
    output logic [1:0]                fsm_state
);

    localparam int MAX_TICKS = (HIGH_TICKS > LOW_TICKS) ? HIGH_TICKS : LOW_TICKS;
    localparam int PH_W      = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [TICK_BITS-1:0] RELOAD_M1 = TICK_BITS'(RELOAD_VALUE - 1);
    localparam logic [PH_W-1:0]      HIGH_END  = PH_W'(HIGH_TICKS - 1);
    localparam logic [PH_W-1:0]      LOW_END   = PH_W'(LOW_TICKS - 1);

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    state_t                    state, state_nxt;
    logic [TICK_BITS-1:0]      tick_cnt;
    logic                      base_tick;
    logic                      go_q;
    logic                      go_rise;
    logic                      mode_run;
    logic                      mode_step;
    logic                      adv_en;
    logic [7:0]                presc [NR_OF_CHANNELS];
    logic [PH_W-1:0]           phase [NR_OF_CHANNELS];
    logic [NR_OF_CHANNELS-1:0] adv;
    logic [NR_OF_CHANNELS-1:0] flip;

    assign base_tick = (tick_cnt == '0);
    assign go_rise   = Go & ~go_q;
    assign mode_run  = (Mode == 2'b01);
    assign mode_step = (Mode == 2'b10);
    assign Running   = (state != HALT);
    assign fsm_state = state;

    // Tick generator ignores the FSM so the base period never drifts.
    always_ff @(posedge GlobalClock) begin
        if (RST) begin
            tick_cnt <= RELOAD_M1;
        end else if (base_tick) begin
            tick_cnt <= RELOAD_M1;
        end else begin
            tick_cnt <= tick_cnt - TICK_BITS'(1);
        end
    end

    // Resetting to 1 means a Go held high across reset release is not an edge.
    always_ff @(posedge GlobalClock) begin
        if (RST) begin
            go_q  <= 1'b1;
            state <= HALT;
        end else begin
            go_q  <= Go;
            state <= state_nxt;
        end
    end

    // Once a stop is pending with channel 0 low, no further advance may start a new period.
    always_comb begin
        state_nxt = state;
        adv_en    = 1'b0;
        case (state)
            HALT: begin
                if (mode_run) begin
                    state_nxt = RUN;
                end else if (go_rise && mode_step) begin
                    state_nxt = STEP;
                end
            end
            RUN: begin
                adv_en = mode_run || ClkLevel[0];
                if (!mode_run && !ClkLevel[0]) begin
                    state_nxt = HALT;
                end
            end
            STEP: begin
                adv_en = !ClkFall[0];
                if (ClkFall[0]) begin
                    state_nxt = HALT;
                end
            end
            default: state_nxt = HALT;
        endcase
    end

    always_comb begin
        adv  = '0;
        flip = '0;
        for (int c = 0; c < NR_OF_CHANNELS; c++) begin
            adv[c]  = base_tick && adv_en && (presc[c] == CH_DIV[8*c +: 8]);
            flip[c] = adv[c] && (ClkLevel[c] ? (phase[c] == HIGH_END) : (phase[c] == LOW_END));
        end
    end

    always_ff @(posedge GlobalClock) begin
        if (RST) begin
            for (int c = 0; c < NR_OF_CHANNELS; c++) begin
                presc[c] <= '0;
                phase[c] <= '0;
            end
            ClkLevel   <= '0;
            ClkRise    <= '0;
            ClkFall    <= '0;
            CycleCount <= '0;
        end else begin
            for (int c = 0; c < NR_OF_CHANNELS; c++) begin
                if (base_tick && adv_en) begin
                    presc[c] <= adv[c] ? 8'd0 : presc[c] + 8'd1;
                end
                if (adv[c]) begin
                    phase[c] <= flip[c] ? '0 : phase[c] + PH_W'(1);
                end
            end
            ClkLevel <= ClkLevel ^ flip;
            ClkRise  <= flip & ~ClkLevel;
            ClkFall  <= flip & ClkLevel;
            if (flip[0] && !ClkLevel[0]) begin
                CycleCount <= CycleCount + 32'd1;
            end
        end
    end

endmodule
